// File: rtl/u_micro_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | u_micro_sequencer_pkg: microword field layout, cond codes, NOP set |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package u_micro_sequencer_pkg;

  localparam int c_DEC_LSB    = 21;
  localparam int c_DEC_W      = 3;
  localparam int c_MUXA_LSB   = 18;
  localparam int c_MUXB_LSB   = 15;
  localparam int c_MUX_W      = 3;
  localparam int c_ALU_LSB    = 11;
  localparam int c_ALU_W      = 4;
  localparam int c_SHLOAD_BIT = 10;
  localparam int c_SHSEL_LSB  = 8;
  localparam int c_SHSEL_W    = 2;
  localparam int c_COND_LSB   = 5;
  localparam int c_COND_W     = 3;
  localparam int c_NEXT_LSB   = 0;
  localparam int c_NEXT_W     = 5;

  localparam logic [2:0] c_COND_SEQ    = 3'b000;
  localparam logic [2:0] c_COND_JUMP   = 3'b001;
  localparam logic [2:0] c_COND_ZERO   = 3'b010;
  localparam logic [2:0] c_COND_NZERO  = 3'b011;
  localparam logic [2:0] c_COND_NEG    = 3'b100;
  localparam logic [2:0] c_COND_CARRY  = 3'b101;
  localparam logic [2:0] c_COND_OVF    = 3'b110;
  localparam logic [2:0] c_COND_HALT   = 3'b111;

  localparam logic [2:0] c_NOP_DEC    = 3'b111;
  localparam logic [2:0] c_NOP_MUX    = 3'b000;
  localparam logic [3:0] c_NOP_ALU    = 4'b0000;
  localparam logic       c_NOP_SHLOAD = 1'b1;
  localparam logic [1:0] c_NOP_SHSEL  = 2'b11;

  // Whole NOP microword; cond=SEQ/next=0 are never executed, only driven.
  localparam logic [23:0] c_NOP_UWORD = {c_NOP_DEC, c_NOP_MUX, c_NOP_MUX, c_NOP_ALU,
                                         c_NOP_SHLOAD, c_NOP_SHSEL, c_COND_SEQ, 5'd0};

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } seqState_t;

endpackage
`default_nettype wire

// File: rtl/u_microcode_store.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | u_microcode_store: 32x24 microcode RAM, sync write, async read     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module u_microcode_store #(
  parameter int DATAWIDTH_UPC   = 5,
  parameter int DATAWIDTH_UWORD = 24
) (
  input  logic                       clk,
  input  logic                       i_wrEn,
  input  logic [DATAWIDTH_UPC-1:0]   i_wrAddr,
  input  logic [DATAWIDTH_UWORD-1:0] i_wrData,
  input  logic [DATAWIDTH_UPC-1:0]   i_rdAddr,
  output logic [DATAWIDTH_UWORD-1:0] o_rdData
);

  logic [DATAWIDTH_UWORD-1:0] r_mem [2**DATAWIDTH_UPC];

  always_ff @(posedge clk) begin
    if (i_wrEn) begin
      r_mem[i_wrAddr] <= i_wrData;
    end
  end

  assign o_rdData = r_mem[i_rdAddr];

endmodule
`default_nettype wire

// File: rtl/u_micro_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | u_micro_sequencer: microprogrammed control unit for 8-bit datapath |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module u_micro_sequencer
  import u_micro_sequencer_pkg::*;
#(
  parameter int DATAWIDTH_DECODER_SELECTION    = 3,
  parameter int DATAWIDTH_MUX_SELECTION        = 3,
  parameter int DATAWIDTH_ALU_SELECTION        = 4,
  parameter int DATAWIDTH_REGSHIFTER_SELECTION = 2,
  parameter int DATAWIDTH_UPC                  = 5,
  parameter int DATAWIDTH_UWORD                = 24
) (
  input  logic                                      uMicroSeq_CLOCK_50,
  input  logic                                      uMicroSeq_Reset_InLow,
  input  logic                                      uMicroSeq_Start_InLow,
  input  logic                                      uMicroSeq_LoadEnable_InLow,
  input  logic [DATAWIDTH_UPC-1:0]                  uMicroSeq_LoadAddress_In,
  input  logic [DATAWIDTH_UWORD-1:0]                uMicroSeq_LoadData_In,
  input  logic                                      uMicroSeq_Overflow_InLow,
  input  logic                                      uMicroSeq_Carry_InLow,
  input  logic                                      uMicroSeq_Negative_InLow,
  input  logic                                      uMicroSeq_Zero_InLow,
  output logic [DATAWIDTH_DECODER_SELECTION-1:0]    uMicroSeq_DecoderSelectionWrite_Out,
  output logic [DATAWIDTH_MUX_SELECTION-1:0]        uMicroSeq_MUXSelectionBUSA_Out,
  output logic [DATAWIDTH_MUX_SELECTION-1:0]        uMicroSeq_MUXSelectionBUSB_Out,
  output logic [DATAWIDTH_ALU_SELECTION-1:0]        uMicroSeq_ALUSelection_Out,
  output logic                                      uMicroSeq_RegSHIFTERLoad_OutLow,
  output logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] uMicroSeq_RegSHIFTERShiftSelection_OutLow,
  output logic                                      uMicroSeq_Busy_Out,
  output logic                                      uMicroSeq_Done_Out,
  output logic [DATAWIDTH_UPC-1:0]                  uMicroSeq_uPC_Out
);

  seqState_t                  r_state;
  logic [DATAWIDTH_UWORD-1:0] r_ir;
  logic [DATAWIDTH_UPC-1:0]   r_upc;
  logic                       r_done;

  logic [c_COND_W-1:0]        w_cond;
  logic [DATAWIDTH_UPC-1:0]   w_jumpAddr;
  logic [DATAWIDTH_UPC-1:0]   w_seqAddr;
  logic                       w_taken;
  logic [DATAWIDTH_UPC-1:0]   w_nextAddr;
  logic [DATAWIDTH_UPC-1:0]   w_rdAddr;
  logic [DATAWIDTH_UWORD-1:0] w_rdData;
  logic                       w_storeWe;
  logic                       w_startReq;

  assign w_cond     = r_ir[c_COND_LSB +: c_COND_W];
  assign w_jumpAddr = r_ir[c_NEXT_LSB +: DATAWIDTH_UPC];
  assign w_seqAddr  = r_upc + 1'b1;

  always_comb begin
    w_taken = 1'b0;
    case (w_cond)
      c_COND_JUMP:  w_taken = 1'b1;
      c_COND_ZERO:  w_taken = ~uMicroSeq_Zero_InLow;
      c_COND_NZERO: w_taken = uMicroSeq_Zero_InLow;
      c_COND_NEG:   w_taken = ~uMicroSeq_Negative_InLow;
      c_COND_CARRY: w_taken = ~uMicroSeq_Carry_InLow;
      c_COND_OVF:   w_taken = ~uMicroSeq_Overflow_InLow;
      default:      w_taken = 1'b0;
    endcase
  end

  assign w_nextAddr = w_taken ? w_jumpAddr : w_seqAddr;
  assign w_rdAddr   = (r_state == S_RUN) ? w_nextAddr : '0;

  // A simultaneous load wins over start, so start needs load idle.
  assign w_storeWe  = (r_state == S_IDLE) && !uMicroSeq_LoadEnable_InLow;
  assign w_startReq = (r_state == S_IDLE) && !uMicroSeq_Start_InLow && uMicroSeq_LoadEnable_InLow;

  u_microcode_store #(
    .DATAWIDTH_UPC   (DATAWIDTH_UPC),
    .DATAWIDTH_UWORD (DATAWIDTH_UWORD)
  ) u_store (
    .clk      (uMicroSeq_CLOCK_50),
    .i_wrEn   (w_storeWe),
    .i_wrAddr (uMicroSeq_LoadAddress_In),
    .i_wrData (uMicroSeq_LoadData_In),
    .i_rdAddr (w_rdAddr),
    .o_rdData (w_rdData)
  );

  always_ff @(posedge uMicroSeq_CLOCK_50 or negedge uMicroSeq_Reset_InLow) begin
    if (!uMicroSeq_Reset_InLow) begin
      r_state <= S_IDLE;
      r_ir    <= c_NOP_UWORD;
      r_upc   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_startReq) begin
            r_ir    <= w_rdData;
            r_upc   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_cond == c_COND_HALT) begin
            r_ir    <= c_NOP_UWORD;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_ir  <= w_rdData;
            r_upc <= w_nextAddr;
          end
        end
        default: begin
          r_ir    <= c_NOP_UWORD;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // IR holds the NOP word whenever idle, so outputs come straight from it.
  assign uMicroSeq_DecoderSelectionWrite_Out       = r_ir[c_DEC_LSB +: DATAWIDTH_DECODER_SELECTION];
  assign uMicroSeq_MUXSelectionBUSA_Out            = r_ir[c_MUXA_LSB +: DATAWIDTH_MUX_SELECTION];
  assign uMicroSeq_MUXSelectionBUSB_Out            = r_ir[c_MUXB_LSB +: DATAWIDTH_MUX_SELECTION];
  assign uMicroSeq_ALUSelection_Out                = r_ir[c_ALU_LSB +: DATAWIDTH_ALU_SELECTION];
  assign uMicroSeq_RegSHIFTERLoad_OutLow           = r_ir[c_SHLOAD_BIT];
  assign uMicroSeq_RegSHIFTERShiftSelection_OutLow = r_ir[c_SHSEL_LSB +: DATAWIDTH_REGSHIFTER_SELECTION];
  assign uMicroSeq_Busy_Out                        = (r_state == S_RUN);
  assign uMicroSeq_Done_Out                        = r_done;
  assign uMicroSeq_uPC_Out                         = r_upc;

endmodule
`default_nettype wire

// File: tb/tb_u_micro_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_u_micro_sequencer: randomized bench with a behavioural model    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_u_micro_sequencer;

  logic        clk = 1'b0;
  logic        rstN;
  logic        startL;
  logic        loadEnL;
  logic [4:0]  loadAddr;
  logic [23:0] loadData;
  logic        ovfL, carryL, negL, zeroL;
  logic [2:0]  dec, muxA, muxB;
  logic [3:0]  alu;
  logic        shLoad;
  logic [1:0]  shSel;
  logic        busy, done;
  logic [4:0]  upc;

  logic [15:0] ctrl;
  assign ctrl = {dec, muxA, muxB, alu, shLoad, shSel};

  localparam logic [15:0] NOP_CTRL = 16'hE007;

  int          nCompared   = 0;
  int          nMismatched = 0;
  int          forceFlag   = -1;
  logic [23:0] mStore [32];

  always #5 clk = ~clk;

  u_micro_sequencer dut (
    .uMicroSeq_CLOCK_50                        (clk),
    .uMicroSeq_Reset_InLow                     (rstN),
    .uMicroSeq_Start_InLow                     (startL),
    .uMicroSeq_LoadEnable_InLow                (loadEnL),
    .uMicroSeq_LoadAddress_In                  (loadAddr),
    .uMicroSeq_LoadData_In                     (loadData),
    .uMicroSeq_Overflow_InLow                  (ovfL),
    .uMicroSeq_Carry_InLow                     (carryL),
    .uMicroSeq_Negative_InLow                  (negL),
    .uMicroSeq_Zero_InLow                      (zeroL),
    .uMicroSeq_DecoderSelectionWrite_Out       (dec),
    .uMicroSeq_MUXSelectionBUSA_Out            (muxA),
    .uMicroSeq_MUXSelectionBUSB_Out            (muxB),
    .uMicroSeq_ALUSelection_Out                (alu),
    .uMicroSeq_RegSHIFTERLoad_OutLow           (shLoad),
    .uMicroSeq_RegSHIFTERShiftSelection_OutLow (shSel),
    .uMicroSeq_Busy_Out                        (busy),
    .uMicroSeq_Done_Out                        (done),
    .uMicroSeq_uPC_Out                         (upc)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic loadWord(input int addr, input logic [23:0] data);
    @(negedge clk);
    loadEnL  = 1'b0;
    loadAddr = addr[4:0];
    loadData = data;
    @(negedge clk);
    loadEnL  = 1'b1;
    mStore[addr] = data;
  endtask

  function automatic logic [23:0] mkWord(input logic [2:0] cond, input int nxt);
    logic [15:0] c;
    c = 16'($urandom);
    return {c, cond, nxt[4:0]};
  endfunction

  // Reference: control = word[23:8], cond = word[7:5], target = word[4:0].
  task automatic runProgram(input int maxWords, input bit noise);
    int pc = 0;
    int n = 0;
    int cond;
    bit takeIt;
    @(negedge clk);
    startL = 1'b0;
    @(negedge clk);
    startL = 1'b1;
    forever begin
      checkVal("uPC", upc, pc);
      checkVal("ctrl", ctrl, mStore[pc][23:8]);
      checkVal("busy", busy, 1);
      checkVal("doneInRun", done, 0);
      n++;
      cond = int'(mStore[pc][7:5]);
      if (n >= maxWords && cond != 7) begin
        rstN = 1'b0;
        #1;
        checkVal("rstCtrl", ctrl, NOP_CTRL);
        checkVal("rstBusy", busy, 0);
        checkVal("rstUpc", upc, 0);
        @(negedge clk);
        rstN = 1'b1;
        return;
      end
      if (forceFlag < 0) {ovfL, carryL, negL, zeroL} = 4'($urandom);
      else {ovfL, carryL, negL, zeroL} = {4{forceFlag[0]}};
      if (noise) begin
        startL   = 1'($urandom);
        loadEnL  = 1'($urandom);
        loadAddr = 5'($urandom);
        loadData = 24'($urandom);
      end
      case (cond)
        1: takeIt = 1;
        2: takeIt = (zeroL == 0);
        3: takeIt = (zeroL == 1);
        4: takeIt = (negL == 0);
        5: takeIt = (carryL == 0);
        6: takeIt = (ovfL == 0);
        default: takeIt = 0;
      endcase
      pc = takeIt ? int'(mStore[pc][4:0]) : (pc + 1) % 32;
      @(negedge clk);
      startL  = 1'b1;
      loadEnL = 1'b1;
      if (cond == 7) begin
        checkVal("haltDone", done, 1);
        checkVal("haltBusy", busy, 0);
        checkVal("haltCtrl", ctrl, NOP_CTRL);
        @(negedge clk);
        checkVal("doneOneCycle", done, 0);
        return;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] d;
    rstN = 1'b0; startL = 1'b1; loadEnL = 1'b1; loadAddr = '0; loadData = '0;
    {ovfL, carryL, negL, zeroL} = 4'hF;
    #12;
    checkVal("resetCtrl", ctrl, NOP_CTRL);
    checkVal("resetBusy", busy, 0);
    checkVal("resetDone", done, 0);
    checkVal("resetUpc", upc, 0);
    @(negedge clk);
    rstN = 1'b1;

    for (int a = 0; a < 32; a++) loadWord(a, mkWord(3'b111, 0));

    // Sequential 0..3 then halt
    for (int a = 0; a < 3; a++) loadWord(a, mkWord(3'b000, 0));
    loadWord(3, mkWord(3'b111, 0));
    runProgram(100, 0);

    // Conditional branches, taken and not taken
    for (int c = 2; c <= 6; c++) begin
      for (int v = 0; v < 2; v++) begin
        loadWord(0, mkWord(3'(c), 5));
        loadWord(1, mkWord(3'b111, 0));
        loadWord(5, mkWord(3'b111, 0));
        forceFlag = v;
        runProgram(100, 0);
      end
    end
    forceFlag = -1;

    // Start and load together: load wins
    d = mkWord(3'b111, 0);
    @(negedge clk);
    startL = 1'b0; loadEnL = 1'b0; loadAddr = 5'd7; loadData = d;
    @(negedge clk);
    startL = 1'b1; loadEnL = 1'b1;
    mStore[7] = d;
    checkVal("startLoadBusy", busy, 0);
    loadWord(0, mkWord(3'b001, 7));
    runProgram(100, 0);

    // Wrap 31 -> 0
    loadWord(0, mkWord(3'b001, 31));
    loadWord(31, mkWord(3'b000, 0));
    runProgram(4, 0);

    // Reset while uPC=2, then rerun from intact store
    for (int a = 0; a < 5; a++) loadWord(a, mkWord(3'b000, 0));
    loadWord(5, mkWord(3'b111, 0));
    runProgram(3, 0);
    runProgram(100, 0);

    // Ignored start/load while busy, confirmed by a clean rerun
    for (int a = 0; a < 4; a++) loadWord(a, mkWord(3'b000, 0));
    loadWord(4, mkWord(3'b111, 0));
    runProgram(100, 1);
    runProgram(100, 0);

    // Random programs with random flags and noise
    for (int r = 0; r < 40; r++) begin
      for (int a = 0; a < 32; a++) loadWord(a, 24'($urandom));
      runProgram(48, 1);
      runProgram(48, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
`default_nettype wire
